ccff_chain_loader: RTL and testbench

Sequencer for the configuration-chain flip-flops that store the routing-mux select bits of a switch block. The block sits between the bitstream source and the block's `ccff_head`/`ccff_tail` pins. It accepts configuration words over a valid/ready handshake and serialises them MSB-first onto the chain. It drives the chain shift-enable so that exactly `CHAIN_LEN` bits are shifted per load. It also runs a chain-integrity test that measures the chain length with a walking one.

---
 rtl/ccff_chain_loader.sv | 145 ++++++++++++++
 tb/tb_ccff_chain_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// Configuration-chain sequencer: serialises words MSB-first onto the
// ccff chain and measures chain length with a walking one.
module ccff_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 20,
  parameter int CNT_W     = $clog2(2*CHAIN_LEN+1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start_load,
  input  logic              start_test,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  bits_shifted
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(2 * CHAIN_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_WAIT,
    S_LD_SHIFT,
    S_TST_SHIFT,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_q, err_d;
  logic              shifting;

  // State and datapath registers
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_load && start_test) begin
          err_d = 1'b1;
        end else if (start_load) begin
          state_d = S_LD_WAIT;
          err_d   = 1'b0;
          cnt_d   = '0;
        end else if (start_test) begin
          state_d = S_TST_SHIFT;
          err_d   = 1'b0;
          cnt_d   = '0;
          sreg_d  = {1'b1, {(WORD_W-1){1'b0}}};
        end
      end
      S_LD_WAIT: begin
        if (word_valid) begin
          sreg_d  = word_in;
          idx_d   = '0;
          state_d = S_LD_SHIFT;
        end
      end
      S_LD_SHIFT: begin
        sreg_d = sreg_q << 1;
        cnt_d  = cnt_q + CNT_W'(1);
        idx_d  = idx_q + IDX_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = S_FINISH;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_LD_WAIT;
        end
      end
      S_TST_SHIFT: begin
        // Tail seen now reflects cnt_q shifts. The deciding cycle
        // still pulses the enable, but the test leaves the chain
        // invalid anyway, so that edge is not counted.
        sreg_d = sreg_q << 1;
        if (cnt_q != '0 && ccff_tail) begin
          if (cnt_q == FULL_CNT) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end else if (cnt_q == LIMIT) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
  end

  assign shifting      = (state_q == S_LD_SHIFT) ||
                         (state_q == S_TST_SHIFT);
  assign ccff_shift_en = shifting;
  assign ccff_head     = shifting & sreg_q[WORD_W-1];
  assign word_ready    = (state_q == S_LD_WAIT);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_FINISH);
  assign err           = err_q;
  assign bits_shifted  = cnt_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized bench for ccff_chain_loader with a behavioural
// chain model and bit-stream reference.
module tb_ccff_chain_loader;

  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 20;
  localparam int CNT_W     = 6;

  logic              prog_clk = 1'b0;
  logic              pReset;
  logic              start_load;
  logic              start_test;
  logic              abort;
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic              ccff_head;
  logic              ccff_tail;
  logic              ccff_shift_en;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  bits_shifted;

  ccff_chain_loader #(
    .WORD_W(WORD_W),
    .CHAIN_LEN(CHAIN_LEN),
    .CNT_W(CNT_W)
  ) dut (
    .prog_clk(prog_clk),
    .pReset(pReset),
    .start_load(start_load),
    .start_test(start_test),
    .abort(abort),
    .word_in(word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .ccff_head(ccff_head),
    .ccff_tail(ccff_tail),
    .ccff_shift_en(ccff_shift_en),
    .busy(busy),
    .done(done),
    .err(err),
    .bits_shifted(bits_shifted)
  );

  always #5 prog_clk = ~prog_clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Chain of flops plus event counters seen on the pins
  logic [39:0] chain;
  int          chain_n = 20;
  bit          tie0 = 1'b0;
  bit          chain_clr = 1'b0;
  int          shifts_seen = 0;
  int          dones_seen = 0;
  int          xfers_seen = 0;
  logic        heads [0:255];

  always @(posedge prog_clk) begin
    if (chain_clr) chain <= '0;
    else if (ccff_shift_en) chain <= {chain[38:0], ccff_head};
    if (ccff_shift_en) begin
      heads[shifts_seen % 256] <= ccff_head;
      shifts_seen <= shifts_seen + 1;
    end
    if (done) dones_seen <= dones_seen + 1;
    if (word_valid && word_ready) xfers_seen <= xfers_seen + 1;
  end

  assign ccff_tail = tie0 ? 1'b0 : chain[chain_n-1];

  task automatic pulse(input bit ld, input bit ts);
    start_load = ld;
    start_test = ts;
    @(negedge prog_clk);
    start_load = 1'b0;
    start_test = 1'b0;
  endtask

  // Full load of three words, optional valid gap before word gap_idx
  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input int gap_idx,
                          input int gap_len, input string tag);
    logic [7:0]  words [3];
    logic [23:0] cat;
    logic [19:0] s;
    logic [19:0] hp;
    int idx, gap, cyc, bs, bd, bx;
    bit seen;
    words = '{w0, w1, w2};
    cat = {w0, w1, w2};
    s = cat[23:4];
    idx = 0;
    gap = (gap_idx >= 0) ? gap_len : 0;
    seen = 1'b0;
    bs = shifts_seen;
    bd = dones_seen;
    bx = xfers_seen;
    pulse(1'b1, 1'b0);
    chk({tag, "_err_clr"}, err, 0);
    cyc = 1;
    while (cyc < 200) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (idx < 3 && !(idx == gap_idx && gap > 0)) begin
        word_valid = 1'b1;
        word_in = words[idx];
      end else begin
        word_valid = 1'b0;
      end
      if (word_valid && word_ready) begin
        idx++;
      end else if (idx == gap_idx && gap > 0 && word_ready) begin
        gap--;
        chk({tag, "_gap_sh"}, ccff_shift_en, 0);
      end
      @(negedge prog_clk);
      cyc++;
    end
    word_valid = 1'b0;
    chk({tag, "_done"}, seen, 1);
    chk({tag, "_cycles"}, cyc,
        24 + ((gap_idx >= 0) ? gap_len : 0));
    chk({tag, "_bits"}, bits_shifted, 20);
    chk({tag, "_err"}, err, 0);
    @(negedge prog_clk);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_shifts"}, shifts_seen - bs, 20);
    chk({tag, "_dones"}, dones_seen - bd, 1);
    chk({tag, "_xfers"}, xfers_seen - bx, 3);
    for (int k = 0; k < 20; k++) hp[19-k] = heads[(bs + k) % 256];
    chk({tag, "_heads"}, hp, s);
    chk({tag, "_chain"}, chain[19:0], s);
    chk({tag, "_hold"}, bits_shifted, 20);
  endtask

  // Integrity test against a chain of n flops (or a tail tied low)
  task automatic run_test(input int n, input bit t0, input string tag);
    int cyc, bd, eb;
    bit pass;
    pass = !t0 && n == CHAIN_LEN;
    eb = t0 ? 2 * CHAIN_LEN : n;
    chain_clr = 1'b1;
    chain_n = n;
    tie0 = t0;
    @(negedge prog_clk);
    chain_clr = 1'b0;
    bd = dones_seen;
    pulse(1'b0, 1'b1);
    cyc = 0;
    while (cyc < 100 && busy && !done) begin
      @(negedge prog_clk);
      cyc++;
    end
    chk({tag, "_bits"}, bits_shifted, eb);
    chk({tag, "_cycles"}, cyc, pass ? CHAIN_LEN + 1 : eb + 1);
    chk({tag, "_err"}, err, pass ? 0 : 1);
    chk({tag, "_donepin"}, done, pass ? 1 : 0);
    @(negedge prog_clk);
    chk({tag, "_dones"}, dones_seen - bd, pass ? 1 : 0);
    chk({tag, "_idle"}, busy, 0);
    tie0 = 1'b0;
    chain_n = CHAIN_LEN;
  endtask

  initial begin
    int bs, cyc;
    bit hit;
    logic [7:0] a, b, c;
    logic [19:0] first;
    pReset = 1'b1;
    start_load = 1'b0;
    start_test = 1'b0;
    abort = 1'b0;
    word_in = '0;
    word_valid = 1'b0;
    chain_clr = 1'b1;
    repeat (2) @(negedge prog_clk);
    chk("rst_outs",
        {word_ready, ccff_head, ccff_shift_en, busy, done, err}, 0);
    chk("rst_bits", bits_shifted, 0);
    pReset = 1'b0;
    chain_clr = 1'b0;
    @(negedge prog_clk);
    chk("idle_busy", busy, 0);

    run_load(8'hA5, 8'h3C, 8'hF0, -1, 0, "dir");
    chk("dir_const", chain[19:0], 20'hA53CF);
    first = chain[19:0];
    run_load(8'hA5, 8'h3C, 8'hF0, 2, 5, "gap");
    chk("gap_same", chain[19:0], first);

    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      c = 8'($urandom);
      run_load(a, b, c, int'($urandom_range(0, 3)) - 1,
               int'($urandom_range(1, 6)), "rnd");
    end

    run_test(20, 1'b0, "tst20");
    run_test(18, 1'b0, "tst18");
    run_test(20, 1'b1, "tst0");
    for (int i = 0; i < 3; i++)
      run_test(int'($urandom_range(12, 30)), 1'b0, "tstr");

    bs = shifts_seen;
    pulse(1'b1, 1'b1);
    chk("both_err", err, 1);
    chk("both_busy", busy, 0);
    repeat (3) @(negedge prog_clk);
    chk("both_busy2", busy, 0);
    chk("both_shifts", shifts_seen - bs, 0);

    bs = shifts_seen;
    hit = 1'b0;
    pulse(1'b1, 1'b0);
    word_valid = 1'b1;
    word_in = 8'h5A;
    cyc = 0;
    while (cyc < 100) begin
      if (shifts_seen - bs == 10 && ccff_shift_en) begin
        abort = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0;
        hit = 1'b1;
        break;
      end
      @(negedge prog_clk);
      cyc++;
    end
    word_valid = 1'b0;
    chk("abt_hit", hit, 1);
    chk("abt_busy", busy, 0);
    chk("abt_err", err, 1);
    chk("abt_bits", bits_shifted, 11);
    chk("abt_shen", ccff_shift_en, 0);
    repeat (3) @(negedge prog_clk);
    chk("abt_shifts", shifts_seen - bs, 11);
    chk("abt_hold", bits_shifted, 11);
    run_load(8'($urandom), 8'($urandom), 8'($urandom), -1, 0, "reld");

    bs = shifts_seen;
    pulse(1'b1, 1'b0);
    word_valid = 1'b1;
    word_in = 8'hC3;
    cyc = 0;
    while (cyc < 100 && shifts_seen - bs < 5) begin
      @(negedge prog_clk);
      cyc++;
    end
    chk("rst_mid_reach", shifts_seen - bs, 5);
    #2 pReset = 1'b1;
    #1;
    chk("rst_async",
        {word_ready, ccff_head, ccff_shift_en, busy, done, err}, 0);
    chk("rst_async_bits", bits_shifted, 0);
    word_valid = 1'b0;
    @(negedge prog_clk);
    pReset = 1'b0;
    @(negedge prog_clk);
    chk("rst_after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
